// File: rtl/uart_byte_tx.sv
// uart_byte_tx: transmits one byte per frame on uart_txd, with optional parity
// and one or two stop bits. A level request is sampled only in IDLE, so an
// upstream controller can queue a second byte by changing data_in after
// tx_busy rises. Both outputs come straight from flip-flops.
module uart_byte_tx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
   parameter int STOP_BITS = 1    // 1 or 2
) (
   input  logic       SYS_CLK,
   input  logic       RST_N,
   input  logic [7:0] data_in,
   input  logic       tx_req,
   output logic       tx_busy,
   output logic       uart_txd
);

   // Cycles per bit. Values below 2 are not a usable configuration.
   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [2:0]       DATA_LAST = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;

   logic             baud_done;
   logic [2:0]       bit_nxt;
   logic             par_bit;

   // Bit-time end strobe, next bit index and the parity bit of the latched byte.
   always_comb begin
      baud_done = (baud_cnt == BAUD_LAST);
      bit_nxt   = bit_cnt + 3'd1;
      par_bit   = (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);
   end

   // Frame sequencer: drives the registered line and busy flag for each state.
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= 8'hFF;
         uart_txd  <= 1'b1;
         tx_busy   <= 1'b0;
      end else begin
         // NOTE: every state register here uses <= so all of them update from
         // the same pre-edge values; a blocking = would let later lines see
         // already-updated counters and skew the bit timing.
         case (state)
            IDLE: begin
               uart_txd <= 1'b1;
               tx_busy  <= 1'b0;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (tx_req) begin
                  shift_reg <= data_in;
                  state     <= START;
                  uart_txd  <= 1'b0;
                  tx_busy   <= 1'b1;
               end
            end

            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  uart_txd <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        state    <= PAR;
                        uart_txd <= par_bit;
                     end else begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                     end
                  end else begin
                     bit_cnt  <= bit_nxt;
                     uart_txd <= shift_reg[bit_nxt];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

            PAR: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= STOP;
                  uart_txd <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                     tx_busy <= 1'b0;
                  end else begin
                     bit_cnt <= bit_nxt;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end

            default: begin
               state    <= IDLE;
               uart_txd <= 1'b1;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench for uart_byte_tx at BAUD_DIV = 10, with four
// instances covering no parity, odd parity, even parity and two stop bits.
module tb_uart_byte_tx;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx_req  = 1'b0;
   logic [3:0] txd;
   logic [3:0] busy;

   int sel        = 0;
   int compared   = 0;
   int mismatched = 0;

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(0), .STOP_BITS(1)) dut_plain (
      .SYS_CLK(clk), .RST_N(rst_n), .data_in(data_in), .tx_req(tx_req),
      .tx_busy(busy[0]), .uart_txd(txd[0]));

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1), .STOP_BITS(1)) dut_odd (
      .SYS_CLK(clk), .RST_N(rst_n), .data_in(data_in), .tx_req(tx_req),
      .tx_busy(busy[1]), .uart_txd(txd[1]));

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(1)) dut_even (
      .SYS_CLK(clk), .RST_N(rst_n), .data_in(data_in), .tx_req(tx_req),
      .tx_busy(busy[2]), .uart_txd(txd[2]));

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
      .SYS_CLK(clk), .RST_N(rst_n), .data_in(data_in), .tx_req(tx_req),
      .tx_busy(busy[3]), .uart_txd(txd[3]));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; returns at the falling edge right
   // after the rising edge that sampled it (cycle 0 of the frame).
   task automatic start_frame(input logic [7:0] d, input bit hold);
      @(negedge clk);
      data_in = d;
      tx_req  = 1'b1;
      @(negedge clk);
      if (!hold) tx_req = 1'b0;
   endtask

   // Follow the selected instance while busy, checking the first and last
   // cycle of every 10-cycle bit slot and the total busy time.
   task automatic run_frame(input string tag, input logic [11:0] frame, input int nbits,
                            input int exp_len, input int disturb_at);
      int cnt = 0;
      while (busy[sel] === 1'b1 && cnt < 300) begin
         if ((cnt / 10) < nbits && ((cnt % 10) == 0 || (cnt % 10) == 9))
            check($sformatf("%s slot%0d+%0d", tag, cnt / 10, cnt % 10), 32'(txd[sel]), 32'(frame[cnt / 10]));
         if (cnt == disturb_at) begin
            data_in = 8'hFF;
            tx_req  = 1'b1;
         end
         if (cnt == disturb_at + 1) tx_req = 1'b0;
         @(negedge clk);
         cnt++;
      end
      check({tag, " busy_len"}, 32'(cnt), 32'(exp_len));
      check({tag, " idle_line"}, 32'(txd[sel]), 32'd1);
   endtask

   // Count cycles in which the selected instance leaves idle.
   task automatic quiet(input string tag, input int n);
      int hits = 0;
      repeat (n) begin
         @(negedge clk);
         if (busy[sel] !== 1'b0 || txd[sel] !== 1'b1) hits++;
      end
      check(tag, 32'(hits), 32'd0);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state on all four instances.
      repeat (3) @(negedge clk);
      check("reset txd", 32'(txd), 32'hF);
      check("reset busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      sel   = 0;
      quiet("post_reset_idle", 20);

      // A pulse that never spans a rising edge is lost.
      @(negedge clk);
      data_in = 8'h12;
      tx_req  = 1'b1;
      #2 tx_req = 1'b0;
      quiet("lost_pulse", 20);

      // Single byte 0x55, one-cycle request pulse.
      sel = 0;
      start_frame(8'h55, 1'b0);
      run_frame("byte55", {1'b1, 8'h55, 1'b0}, 10, 100, 1000);
      quiet("after55", 30);

      // Controller handshake: two frames from one held request.
      start_frame(8'h01, 1'b1);
      data_in = 8'hFE;
      run_frame("hs_first", {1'b1, 8'h01, 1'b0}, 10, 100, 1000);
      @(negedge clk);
      check("hs_gap_one_cycle", 32'(busy[0]), 32'd1);
      tx_req = 1'b0;
      run_frame("hs_second", {1'b1, 8'hFE, 1'b0}, 10, 100, 1000);
      quiet("hs_no_third", 40);

      // Even parity of 0x07 is 1.
      sel = 2;
      start_frame(8'h07, 1'b0);
      run_frame("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 110, 1000);
      quiet("par_even_idle", 30);

      // Odd parity of 0x07 is 0.
      sel = 1;
      start_frame(8'h07, 1'b0);
      run_frame("par_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 110, 1000);
      quiet("par_odd_idle", 30);

      // Two stop bits: 20 high cycles after bit 7.
      sel = 3;
      start_frame(8'hA3, 1'b0);
      run_frame("stop2", {2'b11, 8'hA3, 1'b0}, 11, 110, 1000);
      quiet("stop2_idle", 30);

      // Disturbance during data bit 4 (slot 5) of 0x3C.
      sel = 0;
      start_frame(8'h3C, 1'b0);
      run_frame("disturb", {1'b1, 8'h3C, 1'b0}, 10, 100, 55);
      quiet("disturb_one_frame", 40);

      // Reset during data bit 3 (slot 4) of 0x0F.
      start_frame(8'h0F, 1'b0);
      repeat (45) @(negedge clk);
      check("rst_pre_busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_txd", 32'(txd[0]), 32'd1);
      check("rst_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet("rst_no_resume", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
